// File: rtl/hb_ram_arbiter.sv
// Round-robin two-port arbiter and strobe sequencer for the Hummingbird work RAM.
// Define HB_ARB_LOCK_EN to allow a requester to chain locked back-to-back accesses.
module hb_ram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_LOCK      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [11:0] addr0,
    input  logic [11:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic [7:0]  rdata,
    output logic [11:0] ram_a,
    output logic        ram_ce_b,
    output logic        ram_we_b,
    output logic [7:0]  ram_d_o,
    output logic        ram_d_oe,
    input  logic [7:0]  ram_d_i
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t     state, state_next;
    logic       sel, sel_next;
    logic       last;
    logic       we_q;
    logic [3:0] cnt;
    logic       latch;
    logic       chain;

`ifdef HB_ARB_LOCK_EN
    localparam int LW = $clog2(MAX_LOCK + 1);
    logic [LW-1:0] lock_cnt;

    // lock_cnt counts accesses already finished in this run, so a run is capped at MAX_LOCK.
    always_comb begin
        chain = 1'b0;
        if ((sel ? (lock1 && req1) : (lock0 && req0)) && (int'(lock_cnt) + 1 < MAX_LOCK))
            chain = 1'b1;
    end
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1 ^ (MAX_LOCK == 0);
    assign chain       = 1'b0;
`endif

    always_comb begin
        state_next = state;
        sel_next   = sel;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_next = SETUP;
                    latch      = 1'b1;
                    if (req0 && req1)
                        sel_next = ~last;
                    else
                        sel_next = req1;
                end
            end
            SETUP:  state_next = ACCESS;
            ACCESS: begin
                if (cnt == 4'd0)
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
                if (chain) begin
                    state_next = SETUP;
                    latch      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        gnt0     = (state != IDLE) && !sel;
        gnt1     = (state != IDLE) && sel;
        ack0     = (state == DONE) && !sel;
        ack1     = (state == DONE) && sel;
        ram_ce_b = !((state == SETUP) || (state == ACCESS));
        ram_we_b = !((state == ACCESS) && we_q);
        // Data keeps driving through DONE so the write has hold time after WE rises.
        ram_d_oe = (state != IDLE) && we_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= 1'b0;
            last    <= 1'b1;
            we_q    <= 1'b0;
            cnt     <= 4'd0;
            ram_a   <= 12'd0;
            ram_d_o <= 8'd0;
            rdata   <= 8'd0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
            if (latch) begin
                ram_a   <= sel_next ? addr1 : addr0;
                ram_d_o <= sel_next ? wdata1 : wdata0;
                we_q    <= sel_next ? we1 : we0;
            end
            if (state == SETUP)
                cnt <= CNT_LOAD;
            else if ((state == ACCESS) && (cnt != 4'd0))
                cnt <= cnt - 4'd1;
            if ((state == ACCESS) && (cnt == 4'd0) && !we_q)
                rdata <= ram_d_i;
            if (state == DONE)
                last <= sel;
        end
    end

`ifdef HB_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst)
            lock_cnt <= '0;
        else if (state == IDLE)
            lock_cnt <= '0;
        else if (state == DONE)
            lock_cnt <= lock_cnt + LW'(1);
    end
`endif

endmodule

// File: tb/tb_hb_ram_arbiter.sv
// Directed bench for hb_ram_arbiter: read, write, round-robin, reset abort, req drop, lock runs.
// Expected values are hand-derived for ACCESS_CYCLES=2, MAX_LOCK=4.
module tb_hb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [11:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        gnt0, gnt1, ack0, ack1;
    logic [7:0]  rdata;
    logic [11:0] ram_a;
    logic        ram_ce_b, ram_we_b, ram_d_oe;
    logic [7:0]  ram_d_o, ram_d_i;

    int n_checks = 0;
    int n_errors = 0;
    int overlap  = 0;
    int bad_ack  = 0;

    always #5 clk = ~clk;

    hb_ram_arbiter #(.ACCESS_CYCLES(2), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .ram_a(ram_a), .ram_ce_b(ram_ce_b), .ram_we_b(ram_we_b),
        .ram_d_o(ram_d_o), .ram_d_oe(ram_d_oe), .ram_d_i(ram_d_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; ram_d_i = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Runs until an ack is seen (bounded); who=2 means none arrived.
    task automatic wait_ack(output int who, output int cycles);
        who    = 2;
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cycles++;
            if (gnt0 && gnt1) overlap++;
            if ((ack0 && !gnt0) || (ack1 && !gnt1)) bad_ack++;
            if (ack0 || ack1) begin
                who = ack1 ? 1 : 0;
                break;
            end
        end
    endtask

    logic [5:0] wr_exp [4];
    int who, cyc, acks;
    int order_exp [5];
    int gap_exp;

    initial begin
        // {gnt0, gnt1, ack1, ce_b, we_b, oe} for SETUP, ACCESS, ACCESS, DONE
        wr_exp[0] = 6'b010_011;
        wr_exp[1] = 6'b010_001;
        wr_exp[2] = 6'b010_001;
        wr_exp[3] = 6'b011_111;

        do_reset();
        check("rst_ctl", {gnt0, gnt1, ack0, ack1, ram_ce_b, ram_we_b, ram_d_oe}, 7'b0000110);
        check("rst_a", ram_a, 12'h000);
        check("rst_do", ram_d_o, 8'h00);
        check("rst_rdata", rdata, 8'h00);

        // single read
        req0 = 1; we0 = 0; addr0 = 12'h123; ram_d_i = 8'h5A;
        tick();
        check("rd_setup", {gnt0, gnt1, ram_ce_b, ram_we_b, ram_d_oe}, 5'b10010);
        check("rd_addr", ram_a, 12'h123);
        tick();
        check("rd_acc1_ce", {ram_ce_b, ack0}, 2'b00);
        tick();
        check("rd_acc2_ce", {ram_ce_b, ack0}, 2'b00);
        tick();
        check("rd_done", {gnt0, ack0, ram_ce_b}, 3'b111);
        check("rd_data", rdata, 8'h5A);
        req0 = 0;
        ram_d_i = 8'h11;
        tick();
        check("rd_idle", {gnt0, ack0, ram_ce_b}, 3'b001);
        check("rd_hold", rdata, 8'h5A);

        // single write
        req1 = 1; we1 = 1; addr1 = 12'hFFF; wdata1 = 8'hC3;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("wr_ctl%0d", c), {gnt0, gnt1, ack1, ram_ce_b, ram_we_b, ram_d_oe}, wr_exp[c]);
            check($sformatf("wr_a%0d", c), ram_a, 12'hFFF);
            check($sformatf("wr_do%0d", c), ram_d_o, 8'hC3);
        end
        req1 = 0;
        tick();
        check("wr_idle", {gnt1, ram_d_oe, ram_we_b}, 3'b001);
        check("wr_rdata_kept", rdata, 8'h5A);

        // tie from reset: strict alternation at 3+ACCESS_CYCLES period
        do_reset();
        overlap = 0; bad_ack = 0;
        req0 = 1; req1 = 1; addr0 = 12'h010; addr1 = 12'h020;
        for (int n = 0; n < 4; n++) begin
            wait_ack(who, cyc);
            check($sformatf("rr_who%0d", n), who, n % 2);
            if (n > 0) check($sformatf("rr_gap%0d", n), cyc, 5);
        end
        req0 = 0; req1 = 0;
        tick();
        check("rr_overlap", overlap, 0);
        check("rr_ack_gnt", bad_ack, 0);

        // reset mid-ACCESS after a completed req0 access (pointer then points at 0)
        req0 = 1;
        wait_ack(who, cyc);
        check("pre_rst_who", who, 0);
        req0 = 0;
        tick();
        req0 = 1;
        tick();
        tick();
        check("mid_state", {gnt0, ram_ce_b}, 2'b10);
        rst = 1;
        tick();
        check("mid_rst", {gnt0, gnt1, ack0, ack1, ram_ce_b, ram_we_b, ram_d_oe}, 7'b0000110);
        check("mid_rst_a", ram_a, 12'h000);
        rst = 0; req0 = 0;
        tick();
        check("mid_no_ack", {ack0, gnt0}, 2'b00);
        req1 = 1;
        tick();
        check("post_rst_req1", {gnt0, gnt1}, 2'b01);
        wait_ack(who, cyc);
        check("post_rst_ack1", who, 1);
        req1 = 0;
        tick();
        do_reset();
        req0 = 1; req1 = 1;
        wait_ack(who, cyc);
        check("post_rst_tie", who, 0);
        req0 = 0; req1 = 0;
        tick();

        // req drop after grant
        do_reset();
        req0 = 1; addr0 = 12'h0AB;
        tick();
        check("drop_gnt", gnt0, 1'b1);
        req0 = 0;
        tick();
        wait_ack(who, cyc);
        check("drop_who", who, 0);
        check("drop_lat", cyc, 2);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack0 || ack1) acks++;
        end
        check("drop_once", acks, 0);

        // lock run
`ifdef HB_ARB_LOCK_EN
        order_exp = '{0, 0, 0, 0, 1};
        gap_exp = 4;
`else
        order_exp = '{0, 1, 0, 1, 0};
        gap_exp = 5;
`endif
        do_reset();
        req0 = 1; lock0 = 1; req1 = 1;
        for (int n = 0; n < 5; n++) begin
            wait_ack(who, cyc);
            check($sformatf("lk_who%0d", n), who, order_exp[n]);
            if (n > 0 && n < 4) check($sformatf("lk_gap%0d", n), cyc, gap_exp);
        end
        req0 = 0; req1 = 0; lock0 = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
